alu_operand_sequencer: RTL and testbench

//  Single-button front-end controller for the ALU datapath. Replaces the three load buttons

---
 rtl/alu_operand_sequencer_pkg.sv | 14 +
 rtl/alu_operand_sequencer_btn_debounce.sv | 54 +++++
 rtl/alu_operand_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: state encodings and default widths.
package alu_operand_sequencer_pkg;

  localparam int unsigned NB_DATA_DEF     = 8;
  localparam int unsigned NB_OP_DEF       = 6;
  localparam int unsigned NB_STATE        = 2;
  localparam int unsigned DBNC_CYCLES_DEF = 1000000;

  localparam logic [NB_STATE-1:0] ST_LOAD_A  = 2'b00;
  localparam logic [NB_STATE-1:0] ST_LOAD_B  = 2'b01;
  localparam logic [NB_STATE-1:0] ST_LOAD_OP = 2'b10;
  localparam logic [NB_STATE-1:0] ST_SHOW    = 2'b11;

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
module alu_operand_sequencer_btn_debounce #(
  parameter int unsigned DBNC_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned NB_CNT = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DBNC_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              stable_q;
  logic              stable_d;
  logic              stable_dly_q;
  logic              pulse_q;
  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;

  // Count only while the synced level disagrees with the accepted level; any bounce back restarts.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], i_btn};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      cnt_q        <= cnt_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Single-button ALU front end: STEP walks A -> B -> OP -> SHOW, CLR restarts; result held on LEDs.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA     = NB_DATA_DEF,
  parameter int unsigned NB_OP       = NB_OP_DEF,
  parameter int unsigned DBNC_CYCLES = DBNC_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_dataSw,
  input  logic [NB_OP-1:0]    i_opSw,
  input  logic                i_btnStep,
  input  logic                i_btnClr,
  input  logic [NB_DATA-1:0]  i_aluResult,
  input  logic                i_aluOverflow,
  output logic [NB_DATA-1:0]  o_dataA,
  output logic [NB_DATA-1:0]  o_dataB,
  output logic [NB_OP-1:0]    o_op,
  output logic [NB_DATA-1:0]  o_resultLed,
  output logic                o_overflowLed,
  output logic                o_resultValid,
  output logic [NB_STATE-1:0] o_stateLed
);

  logic step_pulse;
  logic clr_pulse;

  logic [NB_STATE-1:0] state_q,    state_d;
  logic [NB_DATA-1:0]  data_a_q,   data_a_d;
  logic [NB_DATA-1:0]  data_b_q,   data_b_d;
  logic [NB_OP-1:0]    op_q,       op_d;
  logic [NB_DATA-1:0]  result_q,   result_d;
  logic                overflow_q, overflow_d;
  logic                valid_q,    valid_d;

  alu_operand_sequencer_btn_debounce #(
    .DBNC_CYCLES (DBNC_CYCLES)
  ) u_dbnc_step (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btnStep),
    .o_pulse (step_pulse)
  );

  alu_operand_sequencer_btn_debounce #(
    .DBNC_CYCLES (DBNC_CYCLES)
  ) u_dbnc_clr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btnClr),
    .o_pulse (clr_pulse)
  );

  // Next state and register updates; clear overrides a coincident step.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;

    if (clr_pulse) begin
      state_d    = ST_LOAD_A;
      data_a_d   = '0;
      data_b_d   = '0;
      op_d       = '0;
      result_d   = '0;
      overflow_d = 1'b0;
      valid_d    = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (step_pulse) begin
            data_a_d = i_dataSw;
            state_d  = ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (step_pulse) begin
            data_b_d = i_dataSw;
            state_d  = ST_LOAD_OP;
          end
        end
        ST_LOAD_OP: begin
          if (step_pulse) begin
            op_d    = i_opSw;
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          // Valid low in SHOW marks the first cycle, when the ALU already sees the new opcode.
          if (step_pulse) begin
            state_d = ST_LOAD_A;
            valid_d = 1'b0;
          end else if (!valid_q) begin
            result_d   = i_aluResult;
            overflow_d = i_aluOverflow;
            valid_d    = 1'b1;
          end
        end
        default: begin
          state_d = ST_LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_LOAD_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign o_dataA       = data_a_q;
  assign o_dataB       = data_b_q;
  assign o_op          = op_q;
  assign o_resultLed   = result_q;
  assign o_overflowLed = overflow_q;
  assign o_resultValid = valid_q;
  assign o_stateLed    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboarded bench for alu_operand_sequencer with a behavioural ALU and a phase-level sequence model.
module tb_alu_operand_sequencer;

  localparam int unsigned DBNC = 4;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_sw;
  logic [5:0] op_sw;
  logic       btn_step;
  logic       btn_clr;
  logic [7:0] alu_res;
  logic       alu_ovf;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [5:0] op;
  logic [7:0] result_led;
  logic       overflow_led;
  logic       result_valid;
  logic [1:0] state_led;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_operand_sequencer #(
    .NB_DATA     (8),
    .NB_OP       (6),
    .DBNC_CYCLES (DBNC)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_dataSw      (data_sw),
    .i_opSw        (op_sw),
    .i_btnStep     (btn_step),
    .i_btnClr      (btn_clr),
    .i_aluResult   (alu_res),
    .i_aluOverflow (alu_ovf),
    .o_dataA       (data_a),
    .o_dataB       (data_b),
    .o_op          (op),
    .o_resultLed   (result_led),
    .o_overflowLed (overflow_led),
    .o_resultValid (result_valid),
    .o_stateLed    (state_led)
  );

  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] f);
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (f)
      OP_ADD: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = 8'h00;
    endcase
    return {v, r};
  endfunction

  assign {alu_ovf, alu_res} = alu(data_a, data_b, op);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic       ovf;
    int         cyc;
  } sb_t;

  sb_t sbq[$];
  sb_t mon_e;
  int  checks = 0;
  int  errors = 0;

  // Sequence model: phase 0..3 = waiting for A, B, OP, showing.
  int         phase = 0;
  logic [7:0] ma = 0, mb = 0, mled = 0;
  logic [5:0] mop = 0;
  logic       movf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"}, 64'(state_led), 64'(phase));
    chk({tag, "_a"},     64'(data_a), 64'(ma));
    chk({tag, "_b"},     64'(data_b), 64'(mb));
    chk({tag, "_op"},    64'(op), 64'(mop));
    chk({tag, "_led"},   64'(result_led), 64'(mled));
    chk({tag, "_ovf"},   64'(overflow_led), 64'(movf));
    chk({tag, "_valid"}, 64'(result_valid), 64'(phase == 3));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({state_led, data_a, data_b, op, result_led, overflow_led, result_valid});
  endfunction

  task automatic model_clear();
    phase = 0; ma = 0; mb = 0; mop = 0; mled = 0; movf = 0;
  endtask

  task automatic press(input logic s, input logic c, input int hold, input logic push, input sb_t e);
    sb_t ee;
    @(negedge clk);
    ee = e;
    if (push) begin
      ee.cyc = cyc + int'(DBNC) + 5;
      sbq.push_back(ee);
    end
    btn_step = s;
    btn_clr  = c;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_clr  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_step(input logic [7:0] sw_v, input logic [5:0] op_v, input int hold, input string tag);
    sb_t        e;
    logic [8:0] r;
    data_sw = sw_v;
    op_sw   = op_v;
    r       = alu(ma, mb, op_v);
    e.a = ma; e.b = mb; e.op = op_v; e.res = r[7:0]; e.ovf = r[8]; e.cyc = 0;
    press(1'b1, 1'b0, hold, phase == 2, e);
    case (phase)
      0: ma = sw_v;
      1: mb = sw_v;
      2: begin mop = op_v; {movf, mled} = r; end
      default: ;
    endcase
    phase = (phase + 1) % 4;
    check_model(tag);
  endtask

  task automatic do_clear(input logic with_step, input string tag);
    sb_t e;
    e.a = 0; e.b = 0; e.op = 0; e.res = 0; e.ovf = 0; e.cyc = 0;
    press(with_step, 1'b1, 12, 1'b0, e);
    model_clear();
    check_model(tag);
  endtask

  // Monitor: every rising edge of valid must match the oldest expected capture.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && result_valid && !valid_prev) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 64'(result_valid), 64'(0));
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_res", 64'(result_led), 64'(mon_e.res));
        chk("sb_ovf", 64'(overflow_led), 64'(mon_e.ovf));
        chk("sb_a",   64'(data_a), 64'(mon_e.a));
        chk("sb_b",   64'(data_b), 64'(mon_e.b));
        chk("sb_op",  64'(op), 64'(mon_e.op));
        chk("sb_lat", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    valid_prev = result_valid;
  end

  localparam logic [5:0] OPS [4] = '{OP_ADD, OP_SUB, OP_AND, OP_OR};

  initial begin
    int n;
    rst_n    = 1'b0;
    btn_step = 1'b0;
    btn_clr  = 1'b0;
    data_sw  = 8'h00;
    op_sw    = 6'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'(0));
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outs", all_outs(), 64'(0));
    end

    // 05 + 03
    do_step(8'h05, 6'h00, 12, "t2_a");
    do_step(8'h03, 6'h00, 12, "t2_b");
    do_step(8'h00, OP_ADD, 12, "t2_op");
    chk("t2_res", 64'(result_led), 64'(8'h08));

    // SHOW + step returns to LOAD_A, LEDs hold; switches alone do nothing
    do_step(8'h00, 6'h00, 12, "t6_step");
    chk("t6_led_hold", 64'(result_led), 64'(8'h08));
    data_sw = 8'hAA;
    op_sw   = OP_OR;
    repeat (20) @(negedge clk);
    check_model("t6_sw");

    // Back to SHOW, then coincident clr+step
    do_step(8'h05, 6'h00, 12, "t4_a");
    do_step(8'h03, 6'h00, 12, "t4_b");
    do_step(8'h00, OP_ADD, 12, "t4_op");
    do_clear(1'b1, "t4_clr");

    // Short glitch: no advance
    data_sw = 8'h11;
    press(1'b1, 1'b0, 3, 1'b0, mon_e);
    check_model("t3_glitch");

    // Long hold: exactly one advance at the specified latency
    @(negedge clk);
    n = cyc;
    btn_step = 1'b1;
    repeat (DBNC + 3) @(negedge clk);
    chk("t3_before", 64'(state_led), 64'(0));
    @(negedge clk);
    chk("t3_after", 64'(state_led), 64'(1));
    chk("t3_after_a", 64'(data_a), 64'(8'h11));
    chk("t3_cyc", 64'(cyc), 64'(n + int'(DBNC) + 4));
    repeat (20 - DBNC - 4) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    ma = 8'h11;
    phase = 1;
    check_model("t3_one");

    // Mid-sequence reset
    do_clear(1'b0, "t5_clr");
    do_step(8'h7F, 6'h00, 12, "t5_a");
    do_step(8'h01, 6'h00, DBNC, "t5_b_min_hold");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", all_outs(), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check_model("t5_post");
    do_step(8'h7F, 6'h00, 12, "t5_a2");
    do_step(8'h01, 6'h00, 12, "t5_b2");
    do_step(8'h00, OP_ADD, 12, "t5_op2");
    chk("t5_res", 64'(result_led), 64'(8'h80));
    chk("t5_ovf", 64'(overflow_led), 64'(1));

    // Random sequences with occasional clears
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_clear(1'b0, "rnd_clr");
      end else begin
        do_step(8'($urandom), OPS[$urandom_range(0, 3)], 12, "rnd_step");
      end
    end

    // Button held through reset release counts as one press
    @(negedge clk);
    rst_n    = 1'b0;
    btn_step = 1'b1;
    data_sw  = 8'h3C;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (14) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    ma    = 8'h3C;
    phase = 1;
    check_model("held_rst");

    repeat (20) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
